// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand hazard detection, mult/div busy stall and stall counting for the ID stage.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int STALL_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [4:0]         IDRs,
    input  logic [4:0]         IDRt,
    input  logic               IDUseRs,
    input  logic               IDUseRt,
    input  logic               IDBranch,
    input  logic               BranchTaken,
    input  logic [1:0]         jump,
    input  logic               IDMDStart,
    input  logic               IDMDUse,
    input  logic               EXRegWrite,
    input  logic               EXMemRead,
    input  logic [4:0]         EXRd,
    input  logic               MEMMemRead,
    input  logic [4:0]         MEMRd,
    output logic               enableIFIDReg,
    output logic               enablePC,
    output logic               bubbleIDEX,
    output logic               PCsrc,
    output logic               MDBusy,
    output logic [STALL_W-1:0] StallCount
);
    typedef enum logic {RUN, MDBUSY} state_t;
    localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);
    state_t             r_state, w_next;
    logic [5:0]         r_md_cnt, w_md_cnt_next;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_jr, w_br_rs, w_br_rt, w_load_use, w_br_ex, w_br_mem, w_md_stall, w_stall;
    assign w_jr    = jump == 2'd3;
    // jr reads only Rs, so a pending Rt write never holds it back
    assign w_br_rs = (IDBranch && IDUseRs) || w_jr;
    assign w_br_rt = IDBranch && IDUseRt;
    assign w_load_use = EXMemRead && EXRd != 5'd0 &&
                        ((IDUseRs && EXRd == IDRs) || (IDUseRt && EXRd == IDRt));
    assign w_br_ex  = EXRegWrite && EXRd != 5'd0 &&
                      ((w_br_rs && EXRd == IDRs) || (w_br_rt && EXRd == IDRt));
    assign w_br_mem = MEMMemRead && MEMRd != 5'd0 &&
                      ((w_br_rs && MEMRd == IDRs) || (w_br_rt && MEMRd == IDRt));
    assign w_md_stall = r_state == MDBUSY && IDMDUse;
    assign w_stall    = w_load_use || w_br_ex || w_br_mem || w_md_stall;
    assign enableIFIDReg = Reset || !w_stall;
    assign enablePC      = Reset || !w_stall;
    assign bubbleIDEX    = !Reset && w_stall;
    assign PCsrc         = !Reset && !w_stall && ((IDBranch && BranchTaken) || w_jr);
    assign MDBusy        = !Reset && r_state == MDBUSY;
    assign StallCount    = r_stall_cnt;
    always_comb begin
        w_next        = r_state;
        w_md_cnt_next = r_md_cnt;
        if (r_state == RUN) begin
            if (IDMDStart && !w_stall) begin
                w_next        = MDBUSY;
                w_md_cnt_next = MD_LOAD;
            end
        end else if (r_md_cnt == 6'd0) begin
            w_next = RUN;
        end else begin
            w_md_cnt_next = r_md_cnt - 6'd1;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= RUN;
            r_md_cnt    <= 6'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_md_cnt <= w_md_cnt_next;
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors push expected outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] IDRs, IDRt, EXRd, MEMRd;
    logic       IDUseRs, IDUseRt, IDBranch, BranchTaken, IDMDStart, IDMDUse;
    logic       EXRegWrite, EXMemRead, MEMMemRead;
    logic [1:0] jump;
    logic       enableIFIDReg, enablePC, bubbleIDEX, PCsrc, MDBusy;
    logic [3:0] StallCount;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.MD_LATENCY(4), .STALL_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt), .IDUseRs(IDUseRs), .IDUseRt(IDUseRt),
        .IDBranch(IDBranch), .BranchTaken(BranchTaken), .jump(jump), .IDMDStart(IDMDStart),
        .IDMDUse(IDMDUse), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXRd(EXRd),
        .MEMMemRead(MEMMemRead), .MEMRd(MEMRd), .enableIFIDReg(enableIFIDReg), .enablePC(enablePC),
        .bubbleIDEX(bubbleIDEX), .PCsrc(PCsrc), .MDBusy(MDBusy), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [8:0] ex(input bit stall, input bit pcs, input bit mdb, input int cnt);
        return {!stall, !stall, stall, pcs, mdb, 4'(cnt)};
    endfunction

    task automatic clr();
        {IDRs, IDRt, EXRd, MEMRd} = '0;
        {IDUseRs, IDUseRt, IDBranch, BranchTaken, IDMDStart, IDMDUse} = '0;
        {EXRegWrite, EXMemRead, MEMMemRead} = '0;
        jump = 2'd0;
    endtask

    task automatic vec(input string n, input logic [8:0] e);
        exp_t x;
        x.name = n;
        x.v    = e;
        q.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {enableIFIDReg, enablePC, bubbleIDEX, PCsrc, MDBusy, StallCount};
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s got={ifid,pc,bub,pcsrc,md,cnt}=%b expected=%b", e.name, act, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        @(posedge Clk);
        #1;
        vec("rst", ex(0, 0, 0, 0));
        Reset = 1'b0;
        clr(); EXMemRead = 1; EXRd = 5; IDRs = 5; IDUseRs = 1;
        vec("lu", ex(1, 0, 0, 0));
        clr(); MEMMemRead = 1; MEMRd = 5; IDRs = 5; IDUseRs = 1;
        vec("lu_clr", ex(0, 0, 0, 1));
        clr(); EXMemRead = 1; EXRd = 0; IDRs = 0; IDUseRs = 1;
        vec("lu_rd0", ex(0, 0, 0, 1));
        clr(); IDBranch = 1; BranchTaken = 1;
        vec("br_tk", ex(0, 1, 0, 1));
        clr(); IDBranch = 1; BranchTaken = 1; EXRegWrite = 1; EXRd = 7; IDRt = 7; IDUseRt = 1;
        vec("br_dep", ex(1, 0, 0, 1));
        clr(); IDBranch = 1; BranchTaken = 1; IDRt = 7; IDUseRt = 1;
        vec("br_go", ex(0, 1, 0, 2));
        clr(); jump = 3; IDRs = 8; IDUseRs = 1; EXMemRead = 1; EXRegWrite = 1; EXRd = 8;
        vec("jr_ld_ex", ex(1, 0, 0, 2));
        clr(); jump = 3; IDRs = 8; IDUseRs = 1; MEMMemRead = 1; MEMRd = 8;
        vec("jr_ld_mem", ex(1, 0, 0, 3));
        clr(); jump = 3; IDRs = 8; IDUseRs = 1;
        vec("jr_go", ex(0, 1, 0, 4));
        clr(); jump = 1;
        vec("j", ex(0, 0, 0, 4));
        clr(); jump = 3; IDRs = 2; IDRt = 9; EXRegWrite = 1; EXRd = 9;
        vec("jr_rt_ignored", ex(0, 1, 0, 4));
        clr(); IDBranch = 1; BranchTaken = 0;
        vec("br_nt", ex(0, 0, 0, 4));
        clr(); IDMDStart = 1; IDMDUse = 1;
        vec("md_start", ex(0, 0, 0, 4));
        for (int i = 0; i < 4; i++) begin
            clr(); IDMDUse = 1;
            vec("md_busy", ex(1, 0, 1, 4 + i));
        end
        clr(); IDMDUse = 1;
        vec("md_issue", ex(0, 0, 0, 8));
        clr(); IDMDStart = 1; IDMDUse = 1;
        vec("md_start2", ex(0, 0, 0, 8));
        clr();
        vec("md_nonmd", ex(0, 0, 1, 8));
        Reset = 1'b1;
        vec("md_rst", ex(0, 0, 0, 8));
        Reset = 1'b0;
        vec("rst_after", ex(0, 0, 0, 0));
        clr(); IDMDStart = 1; IDMDUse = 1; EXMemRead = 1; EXRd = 3; IDRs = 3; IDUseRs = 1;
        vec("md_lu", ex(1, 0, 0, 0));
        clr();
        vec("md_lu_clr", ex(0, 0, 0, 1));
        for (int i = 0; i < 20; i++) begin
            clr(); EXMemRead = 1; EXRd = 4; IDRt = 4; IDUseRt = 1;
            vec("sat", ex(1, 0, 0, (i + 1 > 15) ? 15 : i + 1));
        end
        clr();
        vec("sat_end", ex(0, 0, 0, 15));
        @(posedge Clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
